alu_seq_ctrl: RTL
=================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port start, input, 1 bit: instruction valid; sampled only in IDLE.
REQ-004 SHALL have port instr, input, 32 bits: instruction word; opcode = instr[31:26], funct = instr[5:0].
REQ-005 SHALL have port zero_flag, input, 1 bit: ALU zero result, sampled in BRANCH.
REQ-006 SHALL have port alu_control, output, 3 bits: ALU op; 001 ADD, 010 SUB, 011 SLT, 100 AND, 101 OR, 110 XOR, 111 NOR, 000 none.
REQ-007 SHALL have port alu_src_b, output, 1 bit: 0 selects register operand, 1 selects sign-extended immediate.
REQ-008 SHALL have ports reg_write, mem_read, mem_write, mem_to_reg, pc_write, output, 1 bit each: datapath strobes.
REQ-009 SHALL have ports busy, done and illegal, output, 1 bit each: busy is high in every non-IDLE state; done and illegal are one-cycle pulses.

Function
REQ-010 SHALL implement states IDLE, DECODE, EXEC, MEM, WB and BRANCH as a registered FSM with registered outputs.
REQ-011 SHALL latch instr into an internal register when start=1 in IDLE and move to DECODE; instr changes after acceptance SHALL have no effect.
REQ-012 In DECODE, SHALL decode the latched instruction. R-type (opcode 000000): funct 100000/100010/101010/100100/100101/100110/100111 map to 001/010/011/100/101/110/111. Opcodes 100011 (lw), 101011 (sw) and 001000 (addi) use ADD with alu_src_b=1. Opcode 000100 (beq) uses SUB with alu_src_b=0.
REQ-013 SHALL treat any other opcode or R-type funct as illegal: pulse illegal for one cycle in DECODE, assert no strobe, and return to IDLE.
REQ-014 SHALL use these transitions: DECODE->EXEC for legal non-beq; DECODE->BRANCH for beq. EXEC->WB for R-type and addi; EXEC->MEM for lw and sw. MEM->WB for lw; MEM->IDLE for sw. WB->IDLE. BRANCH->IDLE.
REQ-015 SHALL drive alu_control and alu_src_b with the decoded values throughout EXEC, MEM, WB and BRANCH, and drive 000/0 in IDLE and DECODE.
REQ-016 SHALL assert mem_read for exactly one cycle in MEM for lw, and mem_write for exactly one cycle in MEM for sw.
REQ-017 SHALL assert reg_write for exactly one cycle in WB, with mem_to_reg=1 for lw and 0 otherwise.
REQ-018 SHALL assert pc_write for one cycle in BRANCH only when zero_flag=1.
REQ-019 SHALL pulse done in the final state of each legal instruction: WB, MEM for sw, or BRANCH.
REQ-020 SHALL give these latencies, counted from the start-accept edge to done high: R-type and addi 3 cycles, lw 4, sw 3, beq 2.
REQ-021 SHALL ignore start when busy=1; no queuing.
REQ-022 SHALL accept a new start in the IDLE cycle immediately after done, giving back-to-back operation.
REQ-023 SHALL never assert mem_read, mem_write, reg_write or pc_write in the same cycle as each other.

Reset
REQ-024 While rst_n=0, SHALL immediately force state=IDLE, all outputs 0 and the latched instruction to 0, independent of clk.
REQ-025 SHALL abort any in-flight instruction on reset, with no strobe issued after reset asserts.
REQ-026 SHALL make the first start acceptance possible on the first rising edge with rst_n=1.

Verification
REQ-027 R-type add: instr=0x012A4020, start pulse -> DECODE, EXEC, WB; alu_control=001 in EXEC/WB; reg_write=1 and done=1 in cycle 3; mem_to_reg=0.
REQ-028 lw: instr=0x8D090004 -> alu_control=001, alu_src_b=1; mem_read=1 in cycle 3; reg_write=1, mem_to_reg=1 and done=1 in cycle 4.
REQ-029 beq: instr=0x11090003 with zero_flag=1 -> alu_control=010 and pc_write=1 with done in cycle 2; repeat with zero_flag=0 -> pc_write=0, done=1.
REQ-030 Illegal: instr=0x00000001 (funct 000001) -> illegal=1 in DECODE, no strobes, back in IDLE with busy=0 next cycle.
REQ-031 Mid-op reset: sw accepted, rst_n=0 asynchronously during EXEC -> all outputs 0 immediately and mem_write never asserts.
REQ-032 Back-to-back: start held high through two R-type xor/nor instructions -> second is accepted on the IDLE cycle after the first done; start while busy is ignored; alu_control sequence 110 then 111.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle FSM sequencing ALU/memory/writeback strobes for a MIPS-like instruction subset
// Ports: clk, rst_n (async, active-low); start/instr accepted in IDLE; zero_flag gates pc_write in BRANCH.
//        alu_control/alu_src_b drive the ALU; reg_write/mem_read/mem_write/mem_to_reg/pc_write are datapath strobes;
//        busy (non-IDLE), done and illegal (one-cycle pulses) report progress.
module alu_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic        zero_flag,
  output logic [2:0]  alu_control,
  output logic        alu_src_b,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        pc_write,
  output logic        busy,
  output logic        done,
  output logic        illegal
);
  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB, BRANCH} state_t;
  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [5:0]  op, fn;
  logic [2:0]  r_ctl, ctl;
  logic        is_r, is_lw, is_sw, is_addi, is_beq, legal, imm, act, br_q;
  logic        unused_ir;
  // Decoding the next instruction value lets every output be registered yet valid in the state it belongs to.
  always_comb begin
    ir_d    = (state_q == IDLE && start) ? instr : ir_q;
    op      = ir_d[31:26];
    fn      = ir_d[5:0];
    is_r    = op == 6'b000000;
    is_lw   = op == 6'b100011;
    is_sw   = op == 6'b101011;
    is_addi = op == 6'b001000;
    is_beq  = op == 6'b000100;
    r_ctl   = fn == 6'b100000 ? 3'b001 :
              fn == 6'b100010 ? 3'b010 :
              fn == 6'b101010 ? 3'b011 :
              fn == 6'b100100 ? 3'b100 :
              fn == 6'b100101 ? 3'b101 :
              fn == 6'b100110 ? 3'b110 :
              fn == 6'b100111 ? 3'b111 : 3'b000;
    imm     = is_lw | is_sw | is_addi;
    legal   = (is_r && r_ctl != 3'b000) || imm || is_beq;
    ctl     = is_r ? r_ctl : is_beq ? 3'b010 : imm ? 3'b001 : 3'b000;
    state_d = state_q == IDLE   ? (start ? DECODE : IDLE) :
              state_q == DECODE ? (!legal ? IDLE : is_beq ? BRANCH : EXEC) :
              state_q == EXEC   ? ((is_lw | is_sw) ? MEM : WB) :
              (state_q == MEM && is_lw) ? WB : IDLE;
    act     = state_d inside {EXEC, MEM, WB, BRANCH};
  end
  assign unused_ir = ^ir_q[25:6];
  // zero_flag is only meaningful while the ALU performs the beq subtract, so it gates the registered branch strobe.
  assign pc_write = br_q & zero_flag;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ir_q        <= '0;
      alu_control <= '0;
      alu_src_b   <= 1'b0;
      reg_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_to_reg  <= 1'b0;
      br_q        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      alu_control <= act ? ctl : 3'b000;
      alu_src_b   <= act & imm;
      reg_write   <= state_d == WB;
      mem_read    <= state_d == MEM && is_lw;
      mem_write   <= state_d == MEM && is_sw;
      mem_to_reg  <= state_d == WB && is_lw;
      br_q        <= state_d == BRANCH;
      busy        <= state_d != IDLE;
      done        <= state_d == WB || state_d == BRANCH || (state_d == MEM && is_sw);
      illegal     <= state_d == DECODE && !legal;
    end
  end
endmodule
